// File: rtl/riscv_run_ctrl.sv
// Boot/run-control sequencer: loads the program, then manages core reset and enable.
// Optional breakpoint unit is built only when RVCTL_BREAKPOINT_EN is defined.
module riscv_run_ctrl #(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = 8,
  parameter int RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              core_en,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic              resume_req,
  input  logic              reload_req,
`ifdef RVCTL_BREAKPOINT_EN
  input  logic              bp_en,
  input  logic [31:0]       bp_addr,
  input  logic [31:0]       core_pc,
  output logic              bp_hit,
`endif
  output logic [1:0]        state,
  output logic [ADDR_W:0]   load_count,
  output logic              load_ovf
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RST  = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } st_t;

  localparam int CW = ADDR_W + 1;
  localparam int RW = (RST_CYCLES < 1) ? 1 : $clog2(RST_CYCLES + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(IMEM_DEPTH - 1);
  localparam logic [RW-1:0] RST_END  = RW'(RST_CYCLES);

  st_t           st;
  logic [CW-1:0] cnt;
  logic          ovf;
  logic [RW-1:0] rcnt;
  logic          step_q;
  logic          step_edge;
  logic          at_end;
  logic          halt_go;
  logic          bp_trig;

  assign step_edge = step_req & ~step_q;
  assign at_end    = ld_last || (cnt == LAST_IDX);
  assign halt_go   = halt_req | bp_trig;

  assign ld_ready   = (st == S_LOAD);
  assign state      = st;
  assign load_count = cnt;
  assign load_ovf   = ovf;

`ifdef RVCTL_BREAKPOINT_EN
  logic skip_bp;
  logic hit;
  logic resuming;

  assign resuming = (st == S_HALT) && resume_req && !halt_req && !reload_req;
  assign bp_trig  = (st == S_RUN) && bp_en && !skip_bp && (core_pc == bp_addr);
  assign bp_hit   = hit;

  // The first RUN cycle after a resume must not re-trap on the same PC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skip_bp <= 1'b0;
      hit     <= 1'b0;
    end else begin
      skip_bp <= resuming;
      if (reload_req || resuming)
        hit <= 1'b0;
      else if (bp_trig)
        hit <= 1'b1;
    end
  end
`else
  assign bp_trig = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st         <= S_LOAD;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      core_rst   <= 1'b1;
      core_en    <= 1'b0;
      cnt        <= '0;
      ovf        <= 1'b0;
      rcnt       <= '0;
      step_q     <= 1'b0;
    end else begin
      step_q  <= step_req;
      imem_we <= 1'b0;
      if (reload_req) begin
        st       <= S_LOAD;
        core_rst <= 1'b1;
        core_en  <= 1'b0;
        cnt      <= '0;
        ovf      <= 1'b0;
        rcnt     <= '0;
      end else begin
        unique case (st)
          S_LOAD: begin
            core_rst <= 1'b1;
            core_en  <= 1'b0;
            if (ld_valid) begin
              imem_we    <= 1'b1;
              imem_waddr <= cnt[ADDR_W-1:0];
              imem_wdata <= ld_data;
              cnt        <= cnt + 1'b1;
              if (at_end) begin
                st   <= S_RST;
                rcnt <= '0;
                ovf  <= !ld_last;
              end
            end
          end
          S_RST: begin
            if (rcnt == RST_END) begin
              st       <= S_RUN;
              core_rst <= 1'b0;
              core_en  <= 1'b1;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          S_RUN: begin
            if (halt_go) begin
              st      <= S_HALT;
              core_en <= 1'b0;
            end
          end
          S_HALT: begin
            if (halt_req) begin
              core_en <= 1'b0;
            end else if (resume_req) begin
              st      <= S_RUN;
              core_en <= 1'b1;
            end else begin
              core_en <= step_edge;
            end
          end
          default: st <= S_LOAD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Randomized self-checking bench for riscv_run_ctrl.
// Breakpoint scenario is compiled in when RVCTL_BREAKPOINT_EN is defined.
module tb_riscv_run_ctrl;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int RC    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_valid;
  logic [31:0]   ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          core_rst;
  logic          core_en;
  logic          halt_req;
  logic          step_req;
  logic          resume_req;
  logic          reload_req;
  logic [1:0]    state;
  logic [AW:0]   load_count;
  logic          load_ovf;
`ifdef RVCTL_BREAKPOINT_EN
  logic          bp_en;
  logic [31:0]   bp_addr;
  logic [31:0]   core_pc;
  logic          bp_hit;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  riscv_run_ctrl #(
    .IMEM_DEPTH(DEPTH),
    .ADDR_W(AW),
    .RST_CYCLES(RC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ld_valid(ld_valid),
    .ld_data(ld_data),
    .ld_last(ld_last),
    .ld_ready(ld_ready),
    .imem_we(imem_we),
    .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata),
    .core_rst(core_rst),
    .core_en(core_en),
    .halt_req(halt_req),
    .step_req(step_req),
    .resume_req(resume_req),
    .reload_req(reload_req),
`ifdef RVCTL_BREAKPOINT_EN
    .bp_en(bp_en),
    .bp_addr(bp_addr),
    .core_pc(core_pc),
    .bp_hit(bp_hit),
`endif
    .state(state),
    .load_count(load_count),
    .load_ovf(load_ovf)
  );

  // Instruction memory model fed by the write port.
  logic [31:0] cap [DEPTH];
  int nwr = 0;
  always @(posedge clk) begin
    if (imem_we) begin
      cap[imem_waddr] <= imem_wdata;
      nwr <= nwr + 1;
    end
  end

`ifdef RVCTL_BREAKPOINT_EN
  // Core model: PC advances one instruction per enabled cycle.
  logic [31:0] pc = 32'd0;
  always @(posedge clk) begin
    if (!rst_n || core_rst) pc <= 32'd0;
    else if (core_en) pc <= pc + 32'd4;
  end
  assign core_pc = pc;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_chk++; if (state !== 2'd0) $display("FAIL rst_state got %0d want 0", state); else n_pass++;
    n_chk++; if (ld_ready !== 1'b1) $display("FAIL rst_ld_ready got %b want 1", ld_ready); else n_pass++;
    n_chk++; if (imem_we !== 1'b0) $display("FAIL rst_we got %b want 0", imem_we); else n_pass++;
    n_chk++; if (imem_waddr !== '0) $display("FAIL rst_waddr got %h want 0", imem_waddr); else n_pass++;
    n_chk++; if (imem_wdata !== 32'd0) $display("FAIL rst_wdata got %h want 0", imem_wdata); else n_pass++;
    n_chk++; if (core_rst !== 1'b1) $display("FAIL rst_core_rst got %b want 1", core_rst); else n_pass++;
    n_chk++; if (core_en !== 1'b0) $display("FAIL rst_core_en got %b want 0", core_en); else n_pass++;
    n_chk++; if (load_count !== '0) $display("FAIL rst_count got %0d want 0", load_count); else n_pass++;
    n_chk++; if (load_ovf !== 1'b0) $display("FAIL rst_ovf got %b want 0", load_ovf); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_midload();
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1;
      ld_data  = $urandom;
      ld_last  = 1'b0;
      tick();
    end
    ld_valid = 1'b0;
    n_chk++; if (load_count !== 9'd2) $display("FAIL mid_count got %0d want 2", load_count); else n_pass++;
    rst_n = 1'b0;
    tick();
    n_chk++; if (load_count !== '0) $display("FAIL midrst_count got %0d want 0", load_count); else n_pass++;
    n_chk++; if (state !== 2'd0) $display("FAIL midrst_state got %0d want 0", state); else n_pass++;
    n_chk++; if (imem_we !== 1'b0) $display("FAIL midrst_we got %b want 0", imem_we); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_basic();
    logic [31:0] prog [5];
    int base;
    int n;
    int extra;
    int bad_rdy;
    prog[0] = 32'h00500093;
    prog[1] = 32'h00700113;
    prog[2] = 32'h002081b3;
    prog[3] = 32'h00302023;
    prog[4] = 32'h00002203;
    base  = nwr;
    extra = 0;
    bad_rdy = 0;
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1;
      ld_data  = prog[i];
      ld_last  = (i == 4);
      tick();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      n_chk++; if (imem_we !== 1'b1) $display("FAIL ld_we[%0d] got %b want 1", i, imem_we); else n_pass++;
      n_chk++; if (imem_waddr !== AW'(i)) $display("FAIL ld_addr[%0d] got %0d want %0d", i, imem_waddr, i); else n_pass++;
      n_chk++; if (imem_wdata !== prog[i]) $display("FAIL ld_data[%0d] got %h want %h", i, imem_wdata, prog[i]); else n_pass++;
      n_chk++; if (load_count !== 9'(i + 1)) $display("FAIL ld_count[%0d] got %0d want %0d", i, load_count, i + 1); else n_pass++;
      if (i < 4) begin
        repeat ($urandom_range(0, 2)) begin
          tick();
          n_chk++; if (imem_we !== 1'b0) $display("FAIL stall_we got %b want 0", imem_we); else n_pass++;
        end
      end
    end
    n_chk++; if (state !== 2'd1) $display("FAIL ld_to_rst got %0d want 1", state); else n_pass++;
    n_chk++; if (load_ovf !== 1'b0) $display("FAIL ld_ovf got %b want 0", load_ovf); else n_pass++;
    ld_valid = 1'b1;
    ld_data  = 32'hdeadbeef;
    n = 0;
    while (core_rst === 1'b1 && n < 10) begin
      if (ld_ready !== 1'b0) bad_rdy++;
      tick();
      n++;
      if (imem_we) extra++;
    end
    n_chk++; if (n !== RC + 1) $display("FAIL rst_len got %0d want %0d", n, RC + 1); else n_pass++;
    n_chk++; if (core_en !== 1'b1) $display("FAIL run_en got %b want 1", core_en); else n_pass++;
    n_chk++; if (state !== 2'd2) $display("FAIL run_state got %0d want 2", state); else n_pass++;
    repeat (4) begin
      if (ld_ready !== 1'b0) bad_rdy++;
      tick();
      if (imem_we) extra++;
    end
    ld_valid = 1'b0;
    tick();
    n_chk++; if (extra !== 0) $display("FAIL extra_writes got %0d want 0", extra); else n_pass++;
    n_chk++; if (bad_rdy !== 0) $display("FAIL ready_outside_load got %0d want 0", bad_rdy); else n_pass++;
    n_chk++; if (nwr - base !== 5) $display("FAIL ld_nwr got %0d want 5", nwr - base); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (cap[i] !== prog[i]) $display("FAIL mem[%0d] got %h want %h", i, cap[i], prog[i]); else n_pass++;
    end
  endtask

  task automatic test_halt_step();
    int pulses;
    int w;
    pulses = 0;
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    n_chk++; if (core_en !== 1'b0) $display("FAIL halt_en got %b want 0", core_en); else n_pass++;
    n_chk++; if (state !== 2'd3) $display("FAIL halt_state got %0d want 3", state); else n_pass++;
    for (int s = 0; s < 3; s++) begin
      repeat ($urandom_range(1, 3)) begin
        tick();
        n_chk++; if (core_en !== 1'b0) $display("FAIL idle_en[%0d] got %b want 0", s, core_en); else n_pass++;
      end
      step_req = 1'b1;
      w = $urandom_range(1, 3);
      for (int c = 0; c < w; c++) begin
        tick();
        if (core_en) pulses++;
        n_chk++;
        if (core_en !== (c == 0)) $display("FAIL step_en[%0d.%0d] got %b want %b", s, c, core_en, c == 0);
        else n_pass++;
      end
      step_req = 1'b0;
      tick();
      if (core_en) pulses++;
      n_chk++; if (core_en !== 1'b0) $display("FAIL step_end[%0d] got %b want 0", s, core_en); else n_pass++;
    end
    n_chk++; if (pulses !== 3) $display("FAIL step_count got %0d want 3", pulses); else n_pass++;
    n_chk++; if (state !== 2'd3) $display("FAIL step_state got %0d want 3", state); else n_pass++;
    halt_req   = 1'b1;
    resume_req = 1'b1;
    tick();
    halt_req = 1'b0;
    n_chk++; if (state !== 2'd3 || core_en !== 1'b0)
      $display("FAIL halt_over_resume got st=%0d en=%b want st=3 en=0", state, core_en);
    else n_pass++;
    tick();
    resume_req = 1'b0;
    n_chk++; if (state !== 2'd2 || core_en !== 1'b1)
      $display("FAIL resume got st=%0d en=%b want st=2 en=1", state, core_en);
    else n_pass++;
    w = 0;
    repeat (4) begin
      tick();
      if (core_en !== 1'b1) w++;
    end
    n_chk++; if (w !== 0) $display("FAIL free_run got %0d low cycles want 0", w); else n_pass++;
  endtask

  task automatic test_reload_step();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    tick();
    reload_req = 1'b1;
    step_req   = 1'b1;
    tick();
    reload_req = 1'b0;
    n_chk++; if (state !== 2'd0) $display("FAIL reload_state got %0d want 0", state); else n_pass++;
    n_chk++; if (core_rst !== 1'b1) $display("FAIL reload_rst got %b want 1", core_rst); else n_pass++;
    n_chk++; if (core_en !== 1'b0) $display("FAIL reload_en got %b want 0", core_en); else n_pass++;
    n_chk++; if (load_count !== '0) $display("FAIL reload_count got %0d want 0", load_count); else n_pass++;
    n_chk++; if (ld_ready !== 1'b1) $display("FAIL reload_ready got %b want 1", ld_ready); else n_pass++;
    tick();
    step_req = 1'b0;
    n_chk++; if (core_en !== 1'b0) $display("FAIL reload_nopulse got %b want 0", core_en); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [31:0] exp_mem [DEPTH];
    int base;
    int n;
    base = nwr;
    for (int i = 0; i < DEPTH; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        ld_valid = 1'b0;
        tick();
      end
      exp_mem[i] = $urandom;
      ld_valid = 1'b1;
      ld_data  = exp_mem[i];
      ld_last  = 1'b0;
      tick();
    end
    n_chk++; if (state !== 2'd1) $display("FAIL ovf_state got %0d want 1", state); else n_pass++;
    n_chk++; if (load_ovf !== 1'b1) $display("FAIL ovf_flag got %b want 1", load_ovf); else n_pass++;
    n_chk++; if (load_count !== 9'd256) $display("FAIL ovf_count got %0d want 256", load_count); else n_pass++;
    ld_data = 32'hffffffff;
    n = 0;
    while (state !== 2'd2 && n < 10) begin
      tick();
      n++;
    end
    n_chk++; if (n !== RC + 1) $display("FAIL ovf_rst_len got %0d want %0d", n, RC + 1); else n_pass++;
    repeat (2) tick();
    ld_valid = 1'b0;
    tick();
    n_chk++; if (load_count !== 9'd256) $display("FAIL sat_count got %0d want 256", load_count); else n_pass++;
    n_chk++; if (nwr - base !== DEPTH) $display("FAIL ovf_nwr got %0d want %0d", nwr - base, DEPTH); else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      n_chk++;
      if (cap[i] !== exp_mem[i]) $display("FAIL ovf_mem[%0d] got %h want %h", i, cap[i], exp_mem[i]);
      else n_pass++;
    end
  endtask

`ifdef RVCTL_BREAKPOINT_EN
  task automatic test_breakpoint();
    int n;
    int low;
    bp_en   = 1'b1;
    bp_addr = 32'h8;
    reload_req = 1'b1;
    tick();
    reload_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1;
      ld_data  = 32'h00000013;
      ld_last  = (i == 2);
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    n = 0;
    while (state !== 2'd2 && n < 10) begin
      tick();
      n++;
    end
    n = 0;
    while (core_en === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_chk++; if (state !== 2'd3) $display("FAIL bp_state got %0d want 3", state); else n_pass++;
    n_chk++; if (bp_hit !== 1'b1) $display("FAIL bp_hit got %b want 1", bp_hit); else n_pass++;
    n_chk++; if (pc !== 32'hc) $display("FAIL bp_pc got %h want c", pc); else n_pass++;
    bp_addr = pc;
    resume_req = 1'b1;
    tick();
    resume_req = 1'b0;
    n_chk++; if (bp_hit !== 1'b0) $display("FAIL bp_clear got %b want 0", bp_hit); else n_pass++;
    low = 0;
    repeat (4) begin
      tick();
      if (core_en !== 1'b1) low++;
    end
    n_chk++; if (low !== 0) $display("FAIL bp_retrap got %0d low cycles want 0", low); else n_pass++;
    n_chk++; if (pc <= 32'hc) $display("FAIL bp_past got %h want above c", pc); else n_pass++;
  endtask
`endif

  initial begin
    rst_n      = 1'b0;
    ld_valid   = 1'b0;
    ld_data    = 32'd0;
    ld_last    = 1'b0;
    halt_req   = 1'b0;
    step_req   = 1'b0;
    resume_req = 1'b0;
    reload_req = 1'b0;
`ifdef RVCTL_BREAKPOINT_EN
    bp_en   = 1'b0;
    bp_addr = 32'd0;
`endif
    test_reset();
    test_reset_midload();
    test_load_basic();
    test_halt_step();
    test_reload_step();
    test_overflow();
`ifdef RVCTL_BREAKPOINT_EN
    test_breakpoint();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/riscv_run_ctrl.md
# riscv_run_ctrl

Boot and run-control sequencer for the single-cycle RISC-V core. It streams a program into instruction memory over a valid/ready load port, holds the core in reset until the load completes, then releases it. After release it gates execution through a clock-enable, with halt, single-step, resume and reload controls. It sits between the top level and the core's reset, enable and instruction-memory write port.

## Interface
Parameters:
- IMEM_DEPTH, 256: instruction-memory words; must be a power of two.
- ADDR_W, 8: word-address width, equal to log2(IMEM_DEPTH).
- RST_CYCLES, 2: cycles `core_rst` is held after a load completes; minimum 1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ld_valid  in  1  a load word is offered.
- ld_data  in  32  load word.
- ld_last  in  1  marks the final word of the program.
- ld_ready  out  1  controller accepts a word; equals (state==LOAD).
- imem_we  out  1  instruction-memory write enable (registered).
- imem_waddr  out  ADDR_W  word write address (registered).
- imem_wdata  out  32  write data (registered).
- core_rst  out  1  active-high reset to the core (registered).
- core_en  out  1  core clock-enable / stall (registered).
- halt_req  in  1  level; stop execution.
- step_req  in  1  rising edge; execute one instruction while halted.
- resume_req  in  1  level; return to free run.
- reload_req  in  1  level; abort and restart the load.
- state  out  2  LOAD=0, RST=1, RUN=2, HALT=3.
- load_count  out  ADDR_W+1  words written in the current load.
- load_ovf  out  1  sticky; memory filled without `ld_last`.

## Operation
- LOAD:
  - `core_rst`=1, `core_en`=0.
  - On handshake (`ld_valid`&&`ld_ready`), write `ld_data` at address `load_count`, then increment `load_count`.
  - Leave for RST on a handshake with `ld_last`=1, or on the handshake that writes address IMEM_DEPTH-1.
  - If the latter occurs with `ld_last`=0, set `load_ovf`.
- RST:
  - `core_rst`=1 for exactly RST_CYCLES cycles (internal counter), then go to RUN.
  - `ld_ready`=0; offered words are not accepted.
- RUN: `core_rst`=0, `core_en`=1.
  - `halt_req`=1 → HALT.
- HALT: `core_en`=0.
  - A rising edge of `step_req` (edge detector, reset value 0) gives `core_en`=1 for exactly one cycle; state stays HALT.
  - `resume_req`=1 → RUN.
- Event priority, highest first: `reload_req` > `halt_req` > `resume_req` > step.
  - `reload_req` from any state → LOAD, clears `load_count`, `load_ovf` and the step pulse; `core_rst`=1 on the next cycle.
  - A step edge coinciding with `resume_req` is dropped.
  - `halt_req` and `resume_req` together in HALT: stay in HALT.
- Load address never wraps; `load_count` saturates at IMEM_DEPTH until the next reload.

## Timing
- Reset values:
  - state=LOAD, `ld_ready`=1, `imem_we`=0, `imem_waddr`=0, `imem_wdata`=0.
  - `core_rst`=1, `core_en`=0, `load_count`=0, `load_ovf`=0.
- Write latency: a handshake at edge k gives `imem_we`=1 with its addr/data during cycle k→k+1.
- The final word's write completes before `core_rst` falls, because RST_CYCLES≥1.
- `core_rst` falls RST_CYCLES+1 edges after the final handshake edge; `core_en` rises at the same edge.
- Halt: `halt_req` sampled at edge k → `core_en`=0 after edge k. The instruction ending at edge k retires; none retire after it.
- Step: an edge detected at edge k → `core_en`=1 during k→k+1 only → exactly one instruction retires at edge k+1.
- Resume: sampled at edge k → `core_en`=1 after edge k.
- `rst_n` low mid-load or mid-run: all state returns to reset values at the next edge; memory contents are untouched.

## Configuration
- `RVCTL_BREAKPOINT_EN` defined:
  - Adds ports `bp_en` (in, 1), `bp_addr` (in, 32), `core_pc` (in, 32) and `bp_hit` (out, 1, sticky).
  - In RUN, `bp_en`&&`core_pc`==`bp_addr` acts as `halt_req` and sets `bp_hit`.
  - The first RUN cycle after a resume ignores the match, so the core can leave the breakpoint.
  - Steps never trigger a breakpoint.
  - `bp_hit` is cleared by resume, reload or reset.
- Not defined: these ports and this logic are absent.

## Test plan
- Load 5 words 0x00500093, 0x00700113, 0x002081b3, 0x00302023, 0x00002203 with `ld_last` on the 5th → writes at addresses 0–4, `load_count`=5, `core_rst` falls 3 edges after the last handshake (RST_CYCLES=2), `load_ovf`=0.
- Stall `ld_valid` between words and offer a word in RUN → no extra writes, `ld_ready`=0 outside LOAD.
- Stream 256 words with `ld_last`=0 → transition to RST after address 255, `load_ovf`=1, `load_count`=256.
- In RUN, assert `halt_req` for 1 cycle, then 3 `step_req` pulses, then `resume_req` → `core_en` shows exactly 3 single-cycle pulses, then stays high.
- `reload_req` asserted while in HALT together with `step_req` → LOAD next cycle, `core_rst`=1, no `core_en` pulse, `load_count`=0.
- With `RVCTL_BREAKPOINT_EN` defined, `bp_addr`=0x8, `core_pc` advancing by 4 each cycle → halt with `core_en`=0 after the edge where `core_pc`=0x8, `bp_hit`=1; resume → continues past 0x8 without re-halting.
